// File: rtl/eth_pattern_checker_pkg.sv
// eth_pattern_checker_pkg: test-frame layout constants and helpers shared with test_gen_pattern
package eth_pattern_checker_pkg;
  localparam logic [15:0] TEST_ETH_TYPE = 16'h88B6;
  localparam int IDX_OFS = 0;
  localparam int TS_OFS = 2;
  localparam int PATTERN_OFS = 4;
  localparam logic [11:0] BYTE_CNT_MAX = 12'd4095;
  function automatic logic [7:0] pattern_byte(input logic [11:0] k, input logic [7:0] idx);
    return k[7:0] + idx;
  endfunction
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction
endpackage

// File: rtl/eth_pattern_checker_sat_counter16.sv
// sat_counter16: 16-bit counter adding amount when en, clamping at 16'hFFFF; ports clk, rst, en, amount, count
module sat_counter16
  import eth_pattern_checker_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] amount,
  output logic [15:0] count
);
  always_ff @(posedge clk)
    count <= rst ? '0 : en ? sat_add16(count, amount) : count;
endmodule

// File: rtl/eth_pattern_checker.sv
// eth_pattern_checker: filters test frames, checks payload pattern, counts good/bad/lost frames, measures latency; ports: clk, rst, timestamp, eth header/payload sink, statistics outputs
module eth_pattern_checker
  import eth_pattern_checker_pkg::*;
#(
  parameter int          DATA_LENGTH = 256,
  parameter logic [15:0] ETH_TYPE    = TEST_ETH_TYPE,
  parameter logic [47:0] LOCAL_MAC   = 48'h01_02_03_04_05_06
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] timestamp,
  input  logic        s_eth_hdr_valid,
  output logic        s_eth_hdr_ready,
  input  logic [47:0] s_eth_dest_mac,
  input  logic [47:0] s_eth_src_mac,
  input  logic [15:0] s_eth_type,
  input  logic [7:0]  s_eth_payload_axis_tdata,
  input  logic        s_eth_payload_axis_tvalid,
  output logic        s_eth_payload_axis_tready,
  input  logic        s_eth_payload_axis_tlast,
  input  logic        s_eth_payload_axis_tuser,
  output logic [15:0] good_count,
  output logic [15:0] bad_count,
  output logic [15:0] lost_count,
  output logic        latency_valid,
  output logic [15:0] latency,
  output logic [15:0] max_latency
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CHECK = 2'd1;
  localparam logic [1:0] DROP = 2'd2;
  logic [1:0] state;
  logic [11:0] cnt;
  logic err, locked;
  logic [15:0] idx, tx_ts, exp_idx, lat_now;
  logic beat, last_beat, mismatch, good_beat, bad_beat, lost_en;
  logic unused_src;
  assign unused_src = ^s_eth_src_mac;
  assign s_eth_hdr_ready = state == IDLE;
  assign s_eth_payload_axis_tready = state != IDLE;
  assign beat = state == CHECK && s_eth_payload_axis_tvalid;
  assign last_beat = beat && s_eth_payload_axis_tlast;
  assign mismatch = cnt >= 12'(PATTERN_OFS) && s_eth_payload_axis_tdata != pattern_byte(cnt, idx[7:0]);
  // Length includes the tlast beat; a short frame can never match since DATA_LENGTH >= 5
  assign good_beat = last_beat && ({1'b0, cnt} + 13'd1 == 13'(DATA_LENGTH)) &&
                     !s_eth_payload_axis_tuser && !err && !mismatch;
  assign bad_beat = last_beat && !good_beat;
  assign lost_en = good_beat && locked && idx != exp_idx;
  assign lat_now = timestamp - tx_ts;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      err <= 1'b0;
      locked <= 1'b0;
      idx <= '0;
      tx_ts <= '0;
      exp_idx <= '0;
      latency_valid <= 1'b0;
      latency <= '0;
      max_latency <= '0;
    end else begin
      latency_valid <= good_beat;
      if (state == IDLE && s_eth_hdr_valid) begin
        state <= (s_eth_type == ETH_TYPE && s_eth_dest_mac == LOCAL_MAC) ? CHECK : DROP;
        cnt <= '0;
        err <= 1'b0;
      end
      if (state != IDLE && state != CHECK && s_eth_payload_axis_tvalid && s_eth_payload_axis_tlast)
        state <= IDLE;
      if (beat) begin
        cnt <= cnt == BYTE_CNT_MAX ? cnt : cnt + 12'd1;
        // A non-last beat at the saturated count means the frame exceeds 4096 bytes
        err <= err | mismatch | (cnt == BYTE_CNT_MAX);
        if (cnt == 12'(IDX_OFS)) idx[15:8] <= s_eth_payload_axis_tdata;
        if (cnt == 12'(IDX_OFS + 1)) idx[7:0] <= s_eth_payload_axis_tdata;
        if (cnt == 12'(TS_OFS)) tx_ts[15:8] <= s_eth_payload_axis_tdata;
        if (cnt == 12'(TS_OFS + 1)) tx_ts[7:0] <= s_eth_payload_axis_tdata;
        if (s_eth_payload_axis_tlast) state <= IDLE;
      end
      if (good_beat) begin
        latency <= lat_now;
        max_latency <= lat_now > max_latency ? lat_now : max_latency;
        exp_idx <= idx + 16'd1;
        locked <= 1'b1;
      end
    end
  end
  sat_counter16 u_good (.clk(clk), .rst(rst), .en(good_beat), .amount(16'd1), .count(good_count));
  sat_counter16 u_bad (.clk(clk), .rst(rst), .en(bad_beat), .amount(16'd1), .count(bad_count));
  sat_counter16 u_lost (.clk(clk), .rst(rst), .en(lost_en), .amount(idx - exp_idx), .count(lost_count));
endmodule
